// File: rtl/page_alloc_if.sv
// Page allocate/return handshake bundle between port controllers and the
// page allocation arbiter.
interface page_alloc_if #(
    parameter int N_PORTS = 16,
    parameter int ADDR_W  = 11
);
    logic [N_PORTS-1:0]        alloc_req;
    logic [N_PORTS-1:0]        alloc_gnt;
    logic [ADDR_W-1:0]         alloc_page;
    logic [N_PORTS-1:0]        free_req;
    logic [N_PORTS*ADDR_W-1:0] free_page;
    logic [N_PORTS-1:0]        free_ack;

    modport master (
        output alloc_req, free_req, free_page,
        input  alloc_gnt, alloc_page, free_ack
    );

    modport slave (
        input  alloc_req, free_req, free_page,
        output alloc_gnt, alloc_page, free_ack
    );
endinterface

// File: rtl/page_alloc_arbiter.sv
// Round-robin pop/push arbiter in front of the null-page FIFO.
// Optional low-watermark priority masking: PAGE_ALLOC_LOW_WM_EN.
module page_alloc_arbiter #(
    parameter int N_PORTS = 16,
    parameter int ADDR_W  = 11,
    parameter int DEPTH   = 2048
`ifdef PAGE_ALLOC_LOW_WM_EN
    ,
    parameter int LOW_WM  = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    page_alloc_if.slave       bus,
    output logic              pop_head,
    input  logic [ADDR_W-1:0] head_addr,
    output logic              push_tail,
    output logic [ADDR_W-1:0] tail_addr,
    output logic [ADDR_W:0]   free_cnt,
    output logic              err_overflow
`ifdef PAGE_ALLOC_LOW_WM_EN
    ,
    input  logic [N_PORTS-1:0] prio_mask,
    output logic               low_wm
`endif
);
    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PORTS - 1);

    logic [IDX_W-1:0]   alloc_ptr;
    logic [IDX_W-1:0]   free_ptr;
    logic [N_PORTS-1:0] alloc_elig;
    logic [N_PORTS-1:0] alloc_win;
    logic [IDX_W-1:0]   alloc_idx;
    logic [IDX_W-1:0]   free_idx;
    logic [ADDR_W-1:0]  free_sel_page;
    logic               full;
    logic               free_any;

    // First set bit strictly after ptr, wrapping.
    function automatic logic [N_PORTS-1:0] rr_pick(
        input logic [N_PORTS-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [N_PORTS-1:0] g;
        logic               found;
        int                 idx;
        g     = '0;
        found = 1'b0;
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = (int'(ptr) + k) % N_PORTS;
            if (!found && req[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [IDX_W-1:0] enc(input logic [N_PORTS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    always_comb begin
        alloc_elig = bus.alloc_req & ~bus.alloc_gnt;
`ifdef PAGE_ALLOC_LOW_WM_EN
        if (low_wm) alloc_elig = alloc_elig & prio_mask;
`endif
        alloc_win = rr_pick(alloc_elig, alloc_ptr);
        alloc_idx = enc(alloc_win);
        pop_head  = (|alloc_elig) && (free_cnt != '0);

        // A full FIFO cannot take a page back: nothing is acked.
        full         = (free_cnt == FULL);
        bus.free_ack = full ? '0 : rr_pick(bus.free_req, free_ptr);
        free_any     = |bus.free_ack;
        free_idx     = enc(bus.free_ack);
        free_sel_page = bus.free_page[int'(free_idx)*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.alloc_gnt  <= '0;
            bus.alloc_page <= '0;
            push_tail      <= 1'b0;
            tail_addr      <= '0;
            free_cnt       <= FULL;
            err_overflow   <= 1'b0;
            alloc_ptr      <= LAST;
            free_ptr       <= LAST;
        end else begin
            bus.alloc_gnt <= pop_head ? alloc_win : '0;
            if (pop_head) begin
                bus.alloc_page <= head_addr;
                alloc_ptr      <= alloc_idx;
            end
            push_tail <= free_any;
            if (free_any) begin
                tail_addr <= free_sel_page;
                free_ptr  <= free_idx;
            end
            unique case ({push_tail, pop_head})
                2'b10:   free_cnt <= free_cnt + 1'b1;
                2'b01:   free_cnt <= free_cnt - 1'b1;
                default: free_cnt <= free_cnt;
            endcase
            if (full && (|bus.free_req)) err_overflow <= 1'b1;
        end
    end

`ifdef PAGE_ALLOC_LOW_WM_EN
    always_ff @(posedge clk) begin
        if (rst) low_wm <= 1'b0;
        else     low_wm <= (free_cnt < (ADDR_W+1)'(LOW_WM));
    end
`endif
endmodule

// File: tb/tb_page_alloc_arbiter.sv
// Directed bench for page_alloc_arbiter with a behavioural null-page FIFO.
module tb_page_alloc_arbiter;
    localparam int NP = 16;
    localparam int AW = 11;
    localparam int DP = 2048;

    logic          clk;
    logic          rst;
    logic          pop_head;
    logic [AW-1:0] head_addr;
    logic          push_tail;
    logic [AW-1:0] tail_addr;
    logic [AW:0]   free_cnt;
    logic          err_overflow;
`ifdef PAGE_ALLOC_LOW_WM_EN
    logic [NP-1:0] prio_mask;
    logic          low_wm;
    assign prio_mask = '1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    page_alloc_if #(.N_PORTS(NP), .ADDR_W(AW)) bus ();

    page_alloc_arbiter #(.N_PORTS(NP), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .pop_head     (pop_head),
        .head_addr    (head_addr),
        .push_tail    (push_tail),
        .tail_addr    (tail_addr),
        .free_cnt     (free_cnt),
        .err_overflow (err_overflow)
`ifdef PAGE_ALLOC_LOW_WM_EN
        ,
        .prio_mask    (prio_mask),
        .low_wm       (low_wm)
`endif
    );

    // Null-page FIFO model: reset full with pages 0..DP-1 in order.
    logic [AW-1:0] mem [DP];
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr;
    assign head_addr = mem[rd_ptr[AW-1:0]];

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= (AW+1)'(DP);
            for (int i = 0; i < DP; i++) mem[i] <= AW'(i);
        end else begin
            if (pop_head) rd_ptr <= rd_ptr + 1'b1;
            if (push_tail) begin
                mem[wr_ptr[AW-1:0]] <= tail_addr;
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_free(input int port, input int page);
        bus.free_page[port*AW +: AW] = AW'(page);
    endtask

    int cyc;

    initial begin
        rst = 1'b1;
        bus.alloc_req = '0;
        bus.free_req  = '0;
        bus.free_page = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_free_cnt", 32'(free_cnt), DP);
        check("rst_gnt", 32'(bus.alloc_gnt), 0);
        check("rst_page", 32'(bus.alloc_page), 0);
        check("rst_ack", 32'(bus.free_ack), 0);
        check("rst_pop", 32'(pop_head), 0);
        check("rst_push", 32'(push_tail), 0);
        check("rst_tail", 32'(tail_addr), 0);
        check("rst_err", 32'(err_overflow), 0);

        // Single request on port 3
        bus.alloc_req = 16'h0008;
        #1;
        check("single_pop", 32'(pop_head), 1);
        tick();
        bus.alloc_req = '0;
        #1;
        check("single_gnt", 32'(bus.alloc_gnt), 32'h0008);
        check("single_page", 32'(bus.alloc_page), 0);
        check("single_cnt", 32'(free_cnt), DP - 1);
        check("single_pop_off", 32'(pop_head), 0);

        // Contention on ports 0..2: rotate 0,1,2 one grant per cycle
        bus.alloc_req = 16'h0007;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("cont_gnt", 32'(bus.alloc_gnt), 32'(1 << (k % 3)));
            check("cont_page", 32'(bus.alloc_page), k + 1);
        end
        bus.alloc_req = '0;
        tick();
        check("cont_cnt", 32'(free_cnt), DP - 7);
        check("cont_gnt_off", 32'(bus.alloc_gnt), 0);

        // Ports 5 and 9 return pages 7 and 8 together
        bus.free_req = 16'h0220;
        set_free(5, 7);
        set_free(9, 8);
        #1;
        check("ret_ack5", 32'(bus.free_ack), 32'h0020);
        tick();
        bus.free_req = 16'h0200;
        #1;
        check("ret_ack9", 32'(bus.free_ack), 32'h0200);
        check("ret_push1", 32'(push_tail), 1);
        check("ret_tail1", 32'(tail_addr), 7);
        check("ret_cnt0", 32'(free_cnt), DP - 7);
        tick();
        bus.free_req = '0;
        #1;
        check("ret_push2", 32'(push_tail), 1);
        check("ret_tail2", 32'(tail_addr), 8);
        check("ret_cnt1", 32'(free_cnt), DP - 6);
        tick();
        check("ret_push_off", 32'(push_tail), 0);
        check("ret_cnt2", 32'(free_cnt), DP - 5);

        // Exhaustion: ports 0 and 1 drain the remaining pages
        bus.alloc_req = 16'h0003;
        cyc = 0;
        while (free_cnt != '0 && cyc < 5000) begin
            tick();
            cyc++;
        end
        check("exh_cycles", cyc, DP - 5);
        check("exh_cnt", 32'(free_cnt), 0);
        #1;
        check("exh_no_pop", 32'(pop_head), 0);
        tick();
        check("exh_no_gnt", 32'(bus.alloc_gnt), 0);

        // Return page 100 on port 2 while requests stay pending
        bus.free_req = 16'h0004;
        set_free(2, 100);
        #1;
        check("exh_ack", 32'(bus.free_ack), 32'h0004);
        check("exh_pop_t", 32'(pop_head), 0);
        tick();
        bus.free_req = '0;
        #1;
        check("exh_push", 32'(push_tail), 1);
        check("exh_tail", 32'(tail_addr), 100);
        check("exh_pop_t1", 32'(pop_head), 0);
        check("exh_gnt_t1", 32'(bus.alloc_gnt), 0);
        tick();
        check("exh_cnt1", 32'(free_cnt), 1);
        check("exh_pop_t2", 32'(pop_head), 1);
        tick();
        check("exh_gnt_t3", 32'(|bus.alloc_gnt), 1);
        check("exh_page100", 32'(bus.alloc_page), 100);
        check("exh_cnt_t3", 32'(free_cnt), 0);
        bus.alloc_req = '0;

        // Reset mid-operation, then overflow return on port 0
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_cnt", 32'(free_cnt), DP);
        check("mid_rst_gnt", 32'(bus.alloc_gnt), 0);
        bus.free_req = 16'h0001;
        set_free(0, 5);
        #1;
        check("ovf_no_ack", 32'(bus.free_ack), 0);
        tick();
        bus.free_req = '0;
        #1;
        check("ovf_no_push", 32'(push_tail), 0);
        check("ovf_err", 32'(err_overflow), 1);
        tick();
        tick();
        check("ovf_err_held", 32'(err_overflow), 1);
        check("ovf_cnt", 32'(free_cnt), DP);

        // Pointer restarts at port 0 after reset
        bus.alloc_req = 16'h8001;
        #1;
        check("ptr_pop", 32'(pop_head), 1);
        tick();
        bus.alloc_req = '0;
        check("ptr_gnt0", 32'(bus.alloc_gnt), 32'h0001);
        check("ptr_page0", 32'(bus.alloc_page), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
